// File: rtl/btb_assoc.sv
// ============================================================================
// btb_assoc : set-associative branch target buffer, combinational lookup,
//             writeback training with per-set round-robin victim selection.
// Revision  : 1.0
// ============================================================================
`default_nettype none

module btb_assoc #(
  parameter int SETS = 16,
  parameter int WAYS = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        flush,
  input  logic [31:0] EIP_fetch,
  output logic        hit,
  output logic        pred_taken,
  output logic [31:0] EIP_target,
  output logic [31:0] FIP_E_target,
  output logic [31:0] FIP_O_target,
  input  logic        LD,
  input  logic [31:0] EIP_WB,
  input  logic        taken_WB,
  input  logic [31:0] target_WB,
  input  logic [31:0] FIP_E_WB,
  input  logic [31:0] FIP_O_WB
);

  localparam int IDX_W = $clog2(SETS);
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_W = 32 - IDX_W;
  localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(WAYS - 1);

  logic             valid_q [SETS][WAYS];
  logic [TAG_W-1:0] tag_q   [SETS][WAYS];
  logic [1:0]       ctr_q   [SETS][WAYS];
  logic [31:0]      tgt_q   [SETS][WAYS];
  logic [31:0]      fe_q    [SETS][WAYS];
  logic [31:0]      fo_q    [SETS][WAYS];
  logic [WAY_W-1:0] vptr_q  [SETS];

  logic [IDX_W-1:0] f_idx, u_idx;
  logic [TAG_W-1:0] f_tag, u_tag;

  assign f_idx = EIP_fetch[IDX_W-1:0];
  assign f_tag = EIP_fetch[31:IDX_W];
  assign u_idx = EIP_WB[IDX_W-1:0];
  assign u_tag = EIP_WB[31:IDX_W];

  // At most one way matches, so OR-ing the gated payloads selects it.
  always_comb begin
    hit          = 1'b0;
    pred_taken   = 1'b0;
    EIP_target   = '0;
    FIP_E_target = '0;
    FIP_O_target = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[f_idx][w] && (tag_q[f_idx][w] == f_tag)) begin
        hit          = 1'b1;
        pred_taken   = pred_taken | ctr_q[f_idx][w][1];
        EIP_target   = EIP_target | tgt_q[f_idx][w];
        FIP_E_target = FIP_E_target | fe_q[f_idx][w];
        FIP_O_target = FIP_O_target | fo_q[f_idx][w];
      end
    end
  end

  logic             u_hit, inv_found;
  logic [WAY_W-1:0] u_way, inv_way, alloc_way, vptr_d;
  logic [1:0]       ctr_cur, ctr_d;

  always_comb begin
    u_hit     = 1'b0;
    u_way     = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[u_idx][w] && (tag_q[u_idx][w] == u_tag)) begin
        u_hit = 1'b1;
        u_way = WAY_W'(w);
      end
      if (!valid_q[u_idx][w] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
    ctr_cur = ctr_q[u_idx][u_way];
    if (taken_WB) ctr_d = (ctr_cur == 2'b11) ? 2'b11 : ctr_cur + 2'b01;
    else          ctr_d = (ctr_cur == 2'b00) ? 2'b00 : ctr_cur - 2'b01;
    alloc_way = inv_found ? inv_way : vptr_q[u_idx];
    vptr_d    = (vptr_q[u_idx] == LAST_WAY) ? '0 : vptr_q[u_idx] + WAY_W'(1);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int s = 0; s < SETS; s++) begin
        vptr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          tag_q[s][w]   <= '0;
          ctr_q[s][w]   <= '0;
          tgt_q[s][w]   <= '0;
          fe_q[s][w]    <= '0;
          fo_q[s][w]    <= '0;
        end
      end
    end else if (flush) begin
      // Tags and payloads are dead once valid is low, so they are left alone.
      for (int s = 0; s < SETS; s++) begin
        vptr_q[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_q[s][w] <= 1'b0;
          ctr_q[s][w]   <= '0;
        end
      end
    end else if (LD) begin
      if (u_hit) begin
        ctr_q[u_idx][u_way] <= ctr_d;
        tgt_q[u_idx][u_way] <= target_WB;
        fe_q[u_idx][u_way]  <= FIP_E_WB;
        fo_q[u_idx][u_way]  <= FIP_O_WB;
      end else if (taken_WB) begin
        valid_q[u_idx][alloc_way] <= 1'b1;
        tag_q[u_idx][alloc_way]   <= u_tag;
        ctr_q[u_idx][alloc_way]   <= 2'b10;
        tgt_q[u_idx][alloc_way]   <= target_WB;
        fe_q[u_idx][alloc_way]    <= FIP_E_WB;
        fo_q[u_idx][alloc_way]    <= FIP_O_WB;
        if (!inv_found) vptr_q[u_idx] <= vptr_d;
      end
    end
  end

endmodule

`default_nettype wire
